// File: rtl/encod_rr.sv
// encod_rr: 16-line event encoder with a one-deep output register.
// Incoming events merge into a pending set. Each load picks one pending line,
// either round-robin from a rotating pointer or by fixed lowest-index priority,
// and presents its binary index on code_o under a valid/ready handshake.
// A repeated event on a line that is already pending is dropped and flagged on ovf_o.
module encod_rr #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_i,
  input  logic        en_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [3:0]  code_o,
  output logic        ovf_o,
  output logic [4:0]  pend_cnt_o
);

  // Registered state and its next-state values
  logic [15:0] pending_q, pending_d;
  logic        valid_q,   valid_d;
  logic [3:0]  code_q,    code_d;
  logic [3:0]  ptr_q,     ptr_d;
  logic        ovf_q,     ovf_d;
  logic [4:0]  cnt_q,     cnt_d;

  // Combinational helpers
  logic [15:0] merged;
  logic [31:0] doubled;
  logic [15:0] rotated;
  logic [3:0]  base;
  logic [3:0]  offset;
  logic [3:0]  sel;
  logic        load;

  // Count the set bits of a 16-bit vector (0..16)
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Merge new events, pick the line to serve, and decide whether to load
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so each path is fully specified and no latch is inferred.
    merged  = pending_q | req_i;
    doubled = '0;
    rotated = merged;
    base    = 4'd0;
    offset  = 4'd0;

    if (RR_EN) begin
      // Rotate the merged set so the pointer position lands at bit 0; the
      // lowest set bit of the rotated view is the first line at or above ptr.
      doubled = {merged, merged} >> ptr_q;
      rotated = doubled[15:0];
      base    = ptr_q;
    end

    // Lowest set bit wins: scan high to low so the last hit is the lowest
    for (int i = 15; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = 4'(i);
      end
    end

    // 4-bit addition wraps 15 -> 0 naturally
    sel  = base + offset;
    load = en_i & (~valid_q | ready_i) & (merged != 16'd0);
  end

  // Next-state for pending set, output register, pointer, overflow and count
  always_comb begin
    pending_d = merged;
    valid_d   = valid_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    ovf_d     = |(req_i & pending_q);

    if (load) begin
      pending_d = merged & ~(16'd1 << sel);
      valid_d   = 1'b1;
      code_d    = sel;
      ptr_d     = sel + 4'd1;
    end else if (valid_q && ready_i) begin
      // Consumer took the code and nothing replaces it; code_o is held
      valid_d   = 1'b0;
    end

    cnt_d = popcount16(pending_d);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every state register is cleared by the async reset so that a
    // reset mid-transfer discards both the held code and all pending events.
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      ptr_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: sequential state is updated with non-blocking '<=' so all
      // registers sample the same pre-edge values.
      pending_q <= pending_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      ptr_q     <= ptr_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_o    = valid_q;
  assign code_o     = code_q;
  assign ovf_o      = ovf_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: doc/encod_rr.md
ENCOD_RR -- requirements
Module: encod_rr

Interface
REQ-001 Parameter: RR_EN, default 1, selects round-robin arbitration (1) or fixed lowest-index priority (0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  16  event lines; a 1 on bit k in a cycle is one event for line k.
REQ-005 en_i  input  1  load enable; gates loading of the output register only.
REQ-006 ready_i  input  1  consumer accepts the current code when high with valid_o.
REQ-007 valid_o  output  1  code_o holds a served event.
REQ-008 code_o  output  4  binary index (0..15) of the served line.
REQ-009 ovf_o  output  1  one-cycle pulse: an event merged into an already-pending line.
REQ-010 pend_cnt_o  output  5  number of pending lines, 0..16, registered.

Function
REQ-011 State: pending[15:0], output register (valid_o, code_o), rr pointer ptr[3:0], ovf_o, pend_cnt_o.
REQ-012 Merged set each cycle: m = pending | req_i.
REQ-013 Load condition: load = en_i & (~valid_o | ready_i) & (m != 0).
REQ-014 Selection, RR_EN=1: first set bit of m searching upward from ptr, wrapping 15 -> 0.
REQ-015 Selection, RR_EN=0: lowest-index set bit of m; ptr is not used.
REQ-016 On load: code_o <= selected index s; valid_o <= 1; pending <= m & ~(1<<s); ptr <= (s+1) mod 16.
REQ-017 Without load: pending <= m; ptr is held.
REQ-018 Accept without reload (valid_o & ready_i & ~load): valid_o <= 0; code_o is held.
REQ-019 Handshake: while valid_o=1 and ready_i=0, code_o and valid_o hold stable regardless of req_i or en_i.
REQ-020 Latency: an event on an idle block (valid_o=0, en_i=1) appears on code_o/valid_o one cycle after the sampling edge.
REQ-021 Back-to-back: with ready_i held high and m nonzero, a new code loads every cycle; throughput is 1 code/cycle.
REQ-022 ovf_o <= |(req_i & pending), using pre-update pending; the excess event is dropped (one event per pending line).
REQ-023 An event on line k while k is in code_o (not in pending) is a new pending event, with no ovf.
REQ-024 en_i=0: no loads; events still merge into pending; accept by ready_i still clears valid_o.
REQ-025 pend_cnt_o <= popcount of next pending value.
REQ-026 Full: with all 16 lines pending, new events set ovf_o only; pend_cnt_o = 16.
REQ-027 Empty: m=0 and accept -> valid_o <= 0; pend_cnt_o = 0.

Reset
REQ-028 When rst_n falls, the block immediately forces pending=0, valid_o=0, code_o=0, ovf_o=0, pend_cnt_o=0, ptr=0, independent of clk.
REQ-029 Reset mid-transfer discards the held code and all pending events; after release, the first load follows REQ-013 to REQ-016 with ptr=0.
REQ-030 The first rising edge with rst_n high is a normal functional edge.

Verification
REQ-031 Single event: idle, en_i=1, req_i=0x0010 for one cycle -> next cycle valid_o=1, code_o=4, pend_cnt_o=0.
REQ-032 Round-robin: RR_EN=1, req_i=0x8001 for one cycle, ready_i=1 -> code_o=0, then 15, then valid_o=0.
- The same stimulus with RR_EN=0 gives the same order.
REQ-033 Fairness: RR_EN=1, lines 2 and 5 re-pulsed after each service, ready_i=1 -> codes alternate 2,5,2,5.
- RR_EN=0 under the same stimulus -> code_o stays 2.
REQ-034 Backpressure: code_o=3 valid, ready_i=0 for 5 cycles while req_i pulses 0x0100 -> code_o stays 3 and pend_cnt_o=1.
- ready_i then goes 1 -> code_o=8 on the next cycle.
REQ-035 Overflow: line 7 pending, ready_i=0, req_i=0x0080 -> ovf_o=1 for exactly one cycle; pend_cnt_o stays 1; only one code 7 is emitted later.
REQ-036 Async reset: valid_o=1 and pend_cnt_o=6, rst_n low mid-cycle -> all outputs 0 before the next edge.
- After release, req_i=0xFFFF -> codes 0,1,2,... in order.
